// File: rtl/cmu_hold_arb_if.sv
// Handshake bundle between the SSP hold requesters, the CMU phase indications
// and the hold arbiter.
interface cmu_hold_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0] hold_req_i;
  logic            phi1_i;
  logic            phi2_i;
  logic            hold_o;
  logic [NREQ-1:0] grant_o;
  logic            busy_o;
  logic            timeout_o;

  modport master (
    output hold_req_i, phi1_i, phi2_i,
    input  hold_o, grant_o, busy_o, timeout_o
  );

  modport slave (
    input  hold_req_i, phi1_i, phi2_i,
    output hold_o, grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/cmu_hold_arb.sv
// Round-robin hold arbiter for the SSP clock management unit: aligns a granted
// hold to phi2, bounds its length to HOLD_MIN..HOLD_MAX and adds a guard cycle.
//
// state     | meaning
// S_IDLE    | no owner, arbitrate pending requests
// S_ALIGN   | owner granted, waiting for a clean phi2
// S_HOLD    | hold_o asserted, counting held cycles
// S_RELEASE | one guard cycle with hold_o low, requests ignored
module cmu_hold_arb #(
  parameter int NREQ     = 2,
  parameter int HOLD_MIN = 2,
  parameter int HOLD_MAX = 12,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          clear,
  cmu_hold_arb_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] L_MIN = CNT_W'(HOLD_MIN);
  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(HOLD_MAX);
  localparam logic [PTR_W-1:0] L_PTR_RST = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ALIGN   = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_grant, w_grant_nxt;
  logic [PTR_W-1:0]  r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]  r_own, w_own_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_hold, w_hold_nxt;
  logic              r_timeout, w_timeout_nxt;

  logic              w_phi2_ok;
  logic              w_own_req;
  logic              w_win_found;
  logic [PTR_W-1:0]  w_win;
  logic [PTR_W-1:0]  w_idx;

  // Both phases high at once is a broken CMU indication; never align to it.
  assign w_phi2_ok = bus.phi2_i & ~bus.phi1_i;
  assign w_own_req = |(bus.hold_req_i & r_grant);

  // Search starts just after the last requester that actually held the clock.
  always_comb begin
    w_win       = r_ptr;
    w_win_found = 1'b0;
    w_idx       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % NREQ);
      if (!w_win_found && bus.hold_req_i[w_idx]) begin
        w_win       = w_idx;
        w_win_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_own_nxt     = r_own;
    w_cnt_nxt     = r_cnt;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_hold_nxt = 1'b0;
        if (w_win_found) begin
          w_grant_nxt = NREQ'(1) << w_win;
          w_own_nxt   = w_win;
          w_state_nxt = S_ALIGN;
        end
      end

      S_ALIGN: begin
        if (!w_own_req) begin
          w_grant_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (w_phi2_ok) begin
          w_hold_nxt  = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
          w_ptr_nxt   = r_own;
          w_state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        if (r_cnt >= L_MIN && !w_own_req) begin
          w_hold_nxt  = 1'b0;
          w_grant_nxt = '0;
          w_state_nxt = S_RELEASE;
        end else if (r_cnt >= L_MAX) begin
          w_hold_nxt    = 1'b0;
          w_grant_nxt   = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        w_hold_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_hold_nxt  = 1'b0;
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_ptr     <= L_PTR_RST;
      r_own     <= '0;
      r_cnt     <= '0;
      r_hold    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_own     <= w_own_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.hold_o    = r_hold;
  assign bus.grant_o   = r_grant;
  assign bus.busy_o    = (r_state != S_IDLE);
  assign bus.timeout_o = r_timeout;

endmodule

// File: tb/tb_cmu_hold_arb.sv
// Directed vector bench for cmu_hold_arb with NREQ=2, HOLD_MIN=2, HOLD_MAX=12.
module tb_cmu_hold_arb;

  logic clk;
  logic clear;
  int   n_cmp;
  int   n_err;

  cmu_hold_arb_if #(.NREQ(2)) bus();

  cmu_hold_arb #(
    .NREQ(2), .HOLD_MIN(2), .HOLD_MAX(12), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       phi1;
    logic       phi2;
    logic       hold;
    logic [1:0] grant;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] req, input logic p1, input logic p2,
                     input logic hold, input logic [1:0] grant,
                     input logic busy, input logic to);
    vec_t v;
    v.req = req; v.phi1 = p1; v.phi2 = p2;
    v.hold = hold; v.grant = grant; v.busy = busy; v.to = to;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant, align on an immediate phi2, hold, release, back to IDLE.
  task automatic do_hold(input string tag, input logic [1:0] exp_grant,
                         input int exp_len, input logic exp_to);
    int len;
    int to_cnt;
    bus.phi2_i = 1'b0;
    tick();
    chk({tag, " grant"}, 8'(bus.grant_o), 8'(exp_grant));
    chk({tag, " align_busy"}, 8'(bus.busy_o), 8'd1);
    bus.phi2_i = 1'b1;
    tick();
    bus.phi2_i = 1'b0;
    chk({tag, " hold_rise"}, 8'(bus.hold_o), 8'd1);
    len    = 1;
    to_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.timeout_o) to_cnt++;
      if (bus.hold_o) len++;
      else break;
    end
    chk({tag, " hold_len"}, 8'(len), 8'(exp_len));
    chk({tag, " rel_timeout"}, 8'(bus.timeout_o), 8'(exp_to));
    chk({tag, " rel_grant"}, 8'(bus.grant_o), 8'd0);
    chk({tag, " rel_busy"}, 8'(bus.busy_o), 8'd1);
    tick();
    if (bus.timeout_o) to_cnt++;
    chk({tag, " idle_busy"}, 8'(bus.busy_o), 8'd0);
    chk({tag, " timeout_pulses"}, 8'(to_cnt), 8'(exp_to));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear = 1'b1;
    bus.hold_req_i = 2'b00;
    bus.phi1_i = 1'b0;
    bus.phi2_i = 1'b0;

    //   req    p1 p2  hold grant busy to
    add(2'b01, 0, 0,  0, 2'b01, 1, 0);  // single requester
    add(2'b01, 0, 0,  0, 2'b01, 1, 0);
    add(2'b01, 0, 0,  0, 2'b01, 1, 0);
    add(2'b01, 0, 1,  1, 2'b01, 1, 0);
    add(2'b01, 0, 0,  1, 2'b01, 1, 0);
    add(2'b01, 0, 0,  1, 2'b01, 1, 0);
    add(2'b00, 0, 0,  0, 2'b00, 1, 0);
    add(2'b00, 0, 0,  0, 2'b00, 0, 0);
    add(2'b01, 0, 1,  0, 2'b01, 1, 0);  // phi2 on grant edge is ignored
    add(2'b01, 1, 1,  0, 2'b01, 1, 0);  // phi1&phi2 illegal
    add(2'b01, 0, 1,  1, 2'b01, 1, 0);
    add(2'b00, 0, 0,  1, 2'b01, 1, 0);  // minimum hold
    add(2'b00, 0, 0,  0, 2'b00, 1, 0);
    add(2'b00, 0, 0,  0, 2'b00, 0, 0);
    add(2'b11, 0, 0,  0, 2'b10, 1, 0);  // round-robin after req0 held
    add(2'b11, 0, 1,  1, 2'b10, 1, 0);
    add(2'b01, 0, 0,  1, 2'b10, 1, 0);
    add(2'b01, 0, 0,  0, 2'b00, 1, 0);
    add(2'b01, 0, 0,  0, 2'b00, 0, 0);  // RELEASE ignores requests
    add(2'b01, 0, 0,  0, 2'b01, 1, 0);
    add(2'b00, 0, 0,  0, 2'b00, 0, 0);  // cancel in ALIGN
    add(2'b11, 0, 0,  0, 2'b01, 1, 0);  // order unchanged by cancel
    add(2'b11, 0, 1,  1, 2'b01, 1, 0);
    add(2'b10, 0, 0,  1, 2'b01, 1, 0);
    add(2'b10, 0, 0,  0, 2'b00, 1, 0);
    add(2'b10, 0, 0,  0, 2'b00, 0, 0);
    add(2'b10, 0, 0,  0, 2'b10, 1, 0);
    add(2'b00, 0, 0,  0, 2'b00, 0, 0);

    #12;
    chk("reset hold", 8'(bus.hold_o), 8'd0);
    chk("reset grant", 8'(bus.grant_o), 8'd0);
    chk("reset busy", 8'(bus.busy_o), 8'd0);
    chk("reset timeout", 8'(bus.timeout_o), 8'd0);
    @(negedge clk);
    clear = 1'b0;
    tick();
    chk("idle after reset", 8'(bus.busy_o), 8'd0);

    for (int i = 0; i < vq.size(); i++) begin
      bus.hold_req_i = vq[i].req;
      bus.phi1_i     = vq[i].phi1;
      bus.phi2_i     = vq[i].phi2;
      tick();
      chk($sformatf("vec%0d hold", i), 8'(bus.hold_o), 8'(vq[i].hold));
      chk($sformatf("vec%0d grant", i), 8'(bus.grant_o), 8'(vq[i].grant));
      chk($sformatf("vec%0d busy", i), 8'(bus.busy_o), 8'(vq[i].busy));
      chk($sformatf("vec%0d timeout", i), 8'(bus.timeout_o), 8'(vq[i].to));
    end
    bus.phi1_i = 1'b0;
    bus.phi2_i = 1'b0;

    // Timeout with requester 1 held forever, then re-granted.
    bus.hold_req_i = 2'b10;
    do_hold("to1", 2'b10, 12, 1'b1);
    do_hold("to1_regrant", 2'b10, 12, 1'b1);

    // Both requesting: alternate owners, each ending by timeout.
    bus.hold_req_i = 2'b11;
    do_hold("rr_a", 2'b01, 12, 1'b1);
    do_hold("rr_b", 2'b10, 12, 1'b1);
    do_hold("rr_c", 2'b01, 12, 1'b1);

    // Asynchronous clear in the middle of a hold.
    tick();
    chk("pre_clr grant", 8'(bus.grant_o), 8'b10);
    bus.phi2_i = 1'b1;
    tick();
    bus.phi2_i = 1'b0;
    tick();
    chk("pre_clr hold", 8'(bus.hold_o), 8'd1);
    #2;
    clear = 1'b1;
    #1;
    chk("clr hold async", 8'(bus.hold_o), 8'd0);
    chk("clr grant async", 8'(bus.grant_o), 8'd0);
    chk("clr busy async", 8'(bus.busy_o), 8'd0);
    @(negedge clk);
    clear = 1'b0;
    tick();
    chk("post_clr grant", 8'(bus.grant_o), 8'b01);
    chk("post_clr hold", 8'(bus.hold_o), 8'd0);
    bus.hold_req_i = 2'b00;
    tick();
    chk("post_clr cancel", 8'(bus.busy_o), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmu_hold_arb.md
# cmu_hold_arb

Hold arbiter and sequencer for the SSP clock management unit. It collects level hold requests from several SSP sub-blocks (for example TX-full and RX-overrun), grants one requester at a time in round-robin order, and aligns the hold to the end of a phi1/phi2 cycle. It drives the CMU hold input for at least `HOLD_MIN` and at most `HOLD_MAX` clocks, then releases the clock with a guard cycle.

## Interface
- `NREQ`, default 2: number of hold requesters, 2..8.
- `HOLD_MIN`, default 2: minimum held cycles, ≥1.
- `HOLD_MAX`, default 12: forced-release limit, > `HOLD_MIN`.
- `CNT_W`, default 4: hold counter width; `HOLD_MAX` < 2^`CNT_W`.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `clear`, input, 1: reset, asynchronous, active-high.
- `hold_req_i`, input, `NREQ`: level hold requests, one bit per requester.
- `phi1_i`, input, 1: CMU phase-1 indication.
- `phi2_i`, input, 1: CMU phase-2 indication.
- `hold_o`, output, 1: registered hold to the CMU (hold-request input, bit 1). A 1 freezes the phases.
- `grant_o`, output, `NREQ`: registered one-hot owner of the current hold sequence.
- `busy_o`, output, 1: 1 whenever the state is not IDLE.
- `timeout_o`, output, 1: one-cycle pulse when a hold is force-released at `HOLD_MAX`.

## Operation
- FSM states: IDLE, ALIGN, HOLD, RELEASE.
- **IDLE**
  - If any `hold_req_i` bit is set, pick the winner by round-robin. The search starts at `ptr+1` mod `NREQ`, where `ptr` is the last requester that reached HOLD.
  - Latch the winner into `grant_o` and go to ALIGN.
- **ALIGN**
  - Waits for `phi2_i`=1.
  - If `phi2_i`=1 and the owner request is still 1: go to HOLD, set `hold_o`=1, set `hold_cnt`=1, set `ptr`=owner.
  - If the owner request drops before that: cancel. Go to IDLE, clear `grant_o`, leave `ptr` unchanged.
  - A `phi2_i` pulse that coincides with the IDLE→ALIGN transition cycle is not used; ALIGN samples only from its first own cycle.
- **HOLD**
  - `hold_o`=1.
  - `hold_cnt` increments each cycle, saturating at `HOLD_MAX`.
  - Normal exit: `hold_cnt` ≥ `HOLD_MIN` and owner request = 0.
  - Forced exit: `hold_cnt` = `HOLD_MAX` with the request still 1. Pulse `timeout_o` in the RELEASE cycle.
  - Either exit: go to RELEASE, clear `hold_o` and `grant_o`.
- **RELEASE**
  - Exactly one cycle. `hold_o`=0; all requests are ignored.
  - Then go to IDLE. This guarantees at least one free-running clock between holds.
- Requests from non-owners during ALIGN, HOLD or RELEASE are not queued. They are re-arbitrated from IDLE.
- A requester still asserting after a timeout is eligible again. Round-robin order lets the other requesters go first.
- `phi1_i` is used only for the alignment sanity flag: `phi1_i` and `phi2_i` both 1 in the same cycle is illegal and is treated as no `phi2_i`.

## Timing
- **Reset values:** state IDLE, `hold_o`=0, `grant_o`=0, `busy_o`=0, `timeout_o`=0, `hold_cnt`=0, `ptr`=`NREQ`-1 (requester 0 wins first).
- **Reset mid-operation:** `hold_o` and `grant_o` drop asynchronously while `clear`=1. Operation restarts from IDLE on the first edge after `clear` falls.
- **Request to grant:** one edge (request sampled at edge n, `grant_o` valid after edge n).
- **Grant to hold:** the edge after the first ALIGN cycle with `phi2_i`=1. Worst case 4 cycles for a free-running 4-slot CMU.
- **Hold length:** `hold_o` stays high for min(max(`HOLD_MIN`, cycles until the request drops), `HOLD_MAX`) cycles.
  - A request dropping in cycle k ≥ `HOLD_MIN` of HOLD releases at the next edge.
- **Minimum gap** between two holds: `hold_o` low for 3 cycles (RELEASE, IDLE, ALIGN with an immediate `phi2_i`).
- `busy_o` is combinational from the state register and has no extra latency.

## Test plan
- **After reset, single requester:** `hold_req_i`=01 held 6 cycles, `phi2_i` every 4th cycle → `grant_o`=01 next edge, `hold_o` rises the edge after `phi2_i`, falls the edge after the request drops, RELEASE one cycle, `timeout_o`=0.
- **Minimum hold:** request a one-cycle pulse that has reached HOLD with `HOLD_MIN`=2 → `hold_o` high exactly 2 cycles.
- **Timeout:** `hold_req_i`=10 held forever with `HOLD_MAX`=12 → `hold_o` high 12 cycles, `timeout_o` pulses once, then re-grant to requester 1 after the gap.
- **Round-robin:** `hold_req_i`=11 constant → grants alternate 01, 10, 01, with each hold ending by timeout.
- **Cancel in ALIGN:** the request drops before `phi2_i` → `hold_o` never rises, `grant_o` clears, the next grant order is unchanged.
- **Reset in HOLD:** assert `clear` mid-hold → `hold_o`=0 and `grant_o`=0 immediately without waiting for `clk`. After release, requester 0 has first priority.
